// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
// State, owner and the fixed fetch access size live here.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [2:0] FETCH_OP = 3'b010;

endpackage

// File: rtl/mem_arb_sel.sv
// Grant selection: load/store first, fetch forced in
// once the load/store streak reaches its limit.
module mem_arb_sel #(
  parameter int SW           = 3,
  parameter int MAX_LS_BURST = 4
) (
  input  logic          if_valid,
  input  logic          ls_valid,
  input  logic [SW-1:0] streak,
  output logic          grant_if,
  output logic          grant_ls
);

  localparam logic [SW-1:0] MAX_S = SW'(MAX_LS_BURST);

  logic starve;

  assign starve   = if_valid && (streak == MAX_S);
  assign grant_ls = ls_valid && !starve;
  assign grant_if = if_valid && !grant_ls;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between instruction fetch and
// load/store onto one shared memory request/response port.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int MAX_LS_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  input  logic [XLEN-1:0] if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [31:0]     if_rsp_data,
  input  logic            ls_req_valid,
  input  logic [XLEN-1:0] ls_req_addr,
  input  logic            ls_req_wr,
  input  logic [XLEN-1:0] ls_req_wdata,
  input  logic [2:0]      ls_req_op,
  output logic            ls_req_ready,
  output logic            ls_rsp_valid,
  output logic [XLEN-1:0] ls_rsp_data,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [2:0]      mem_req_op,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data
);

  localparam int SW = $clog2(MAX_LS_BURST + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_LS_BURST);

  logic [1:0]      state;
  logic            owner;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            wr_q;
  logic [2:0]      op_q;
  logic [SW-1:0]   streak;
  logic            grant_if;
  logic            grant_ls;
  logic            idle;
  logic            rsp_hit;
  logic [31:0]     word;

  mem_arb_sel #(
    .SW           (SW),
    .MAX_LS_BURST (MAX_LS_BURST)
  ) u_sel (
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .streak   (streak),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  assign idle = (state == ST_IDLE);

  // Readies and pulses are gated by rst_n so nothing leaks out while held in reset.
  assign if_req_ready = rst_n && idle && grant_if;
  assign ls_req_ready = rst_n && idle && grant_ls;

  assign rsp_hit      = rst_n && (state == ST_WAIT) && mem_rsp_valid;
  assign if_rsp_valid = rsp_hit && (owner == OWN_IF);
  assign ls_rsp_valid = rsp_hit && (owner == OWN_LS);

  generate
    if (XLEN > 32) begin : g_wide
      assign word = addr_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
    end else begin : g_narrow
      assign word = mem_rsp_data[31:0];
    end
  endgenerate

  assign if_rsp_data = if_rsp_valid ? word : 32'd0;
  assign ls_rsp_data = ls_rsp_valid ? mem_rsp_data : '0;

  assign mem_req_valid = (state == ST_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wr    = wr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_op    = op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= OWN_IF;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      op_q    <= 3'd0;
      streak  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ls) begin
            owner   <= OWN_LS;
            addr_q  <= ls_req_addr;
            wdata_q <= ls_req_wdata;
            wr_q    <= ls_req_wr;
            op_q    <= ls_req_op;
            state   <= ST_ISSUE;
          end else if (grant_if) begin
            owner   <= OWN_IF;
            addr_q  <= if_req_addr;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            op_q    <= FETCH_OP;
            state   <= ST_ISSUE;
          end
          if (!if_req_valid || grant_if)
            streak <= '0;
          else if (grant_ls && streak != MAX_S)
            streak <= streak + SW'(1);
        end
        ST_ISSUE: if (mem_req_ready) state <= ST_WAIT;
        ST_WAIT:  if (mem_rsp_valid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
